// File: rtl/ram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_ctrl_pkg
// Purpose  : Shared types and constants for the dual-port RAM port master.
//            Holds the master FSM state encoding, default bus widths, the
//            RAM read latency and a saturating-increment helper used by the
//            optional statistics counters (RAM_CTRL_STATS_EN).
// Revision : 1.0 - initial release
// ============================================================================
package ram_ctrl_pkg;

    localparam int DEFAULT_AW = 8;
    localparam int DEFAULT_DW = 8;
    localparam int DEFAULT_LW = 4;

    // Cycles between a read being issued and its data appearing on ram_data.
    localparam int RD_LAT = 1;

    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD      = 2'd2,
        RD_LAST = 2'd3
    } state_t;

    // Saturating +1 for the statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_ctrl_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : ram_ctrl_addr_gen
// Purpose  : Burst address / beat counter pair. Loads a start address and
//            beats-minus-one count, advances once per issued beat and flags
//            the final beat.
// Ports    : clk, rst_n     - clock, async active-low reset
//            i_load         - load i_addr / i_len
//            i_addr, i_len  - burst start address, beats minus one
//            i_advance      - a beat was issued this cycle
//            o_addr         - current beat address
//            o_last         - current beat is the last of the burst
// Revision : 1.0 - initial release
// ============================================================================
module ram_ctrl_addr_gen
    import ram_ctrl_pkg::*;
#(
    parameter int AW = DEFAULT_AW,
    parameter int LW = DEFAULT_LW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [AW-1:0] i_addr,
    input  logic [LW-1:0] i_len,
    input  logic          i_advance,
    output logic [AW-1:0] o_addr,
    output logic          o_last
);

    logic [AW-1:0] r_addr;
    logic [LW-1:0] r_remaining;
    logic          w_last;

    assign w_last = (r_remaining == '0);

    // On the final beat the address is held rather than stepped, so the
    // read tail cycle keeps presenting the last word's address and the
    // counter never underflows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
        end else if (i_load) begin
            r_addr      <= i_addr;
            r_remaining <= i_len;
        end else if (i_advance && !w_last) begin
            r_addr      <= r_addr + AW'(1);   // wraps modulo 2^AW
            r_remaining <= r_remaining - LW'(1);
        end
    end

    assign o_addr = r_addr;
    assign o_last = w_last;

endmodule
`default_nettype wire

// File: rtl/ram_dp_port_master.sv
`default_nettype none
// ============================================================================
// Module   : ram_dp_port_master
// Purpose  : Initiator for one port of the dual-port RAM. Turns a valid/ready
//            command plus a write-data stream into RAM cs/we/oe cycles and
//            returns read data as a valid-qualified stream. Single accesses
//            and incrementing bursts of cmd_len+1 beats.
// Ports    : clk, rst_n                       - clock, async active-low reset
//            cmd_valid/ready/we/addr/len      - burst command handshake
//            wr_valid/ready/data              - write beat stream
//            rd_valid/rd_data                 - read beat stream (no stall)
//            busy                             - burst or read data in flight
//            ram_address/data/cs/we/oe        - RAM port (data bidirectional)
//            stat_wr_cnt/stat_rd_cnt          - only with RAM_CTRL_STATS_EN
// Options  : RAM_CTRL_STATS_EN adds saturating 16-bit beat counters.
// Revision : 1.0 - initial release
// ============================================================================
module ram_dp_port_master
    import ram_ctrl_pkg::*;
#(
    parameter int AW = DEFAULT_AW,
    parameter int DW = DEFAULT_DW,
    parameter int LW = DEFAULT_LW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          busy,
`ifdef RAM_CTRL_STATS_EN
    output logic [15:0]   stat_wr_cnt,
    output logic [15:0]   stat_rd_cnt,
`endif
    output logic [AW-1:0] ram_address,
    inout  wire  [DW-1:0] ram_data,
    output logic          ram_cs,
    output logic          ram_we,
    output logic          ram_oe
);

    state_t            r_state;
    logic              w_busy;
    logic              w_accept;
    logic              w_wr_beat;
    logic              w_rd_issue;
    logic              w_advance;
    logic              w_last;
    logic [AW-1:0]     w_cur_addr;
    logic              w_drive;
    logic              w_capture;
    logic              w_pipe_busy;
    logic [RD_LAT-1:0] r_issue_pipe;
    logic              r_rd_valid;
    logic [DW-1:0]     r_rd_data;

    assign w_accept   = (r_state == IDLE) && cmd_valid && !w_busy;
    assign w_wr_beat  = (r_state == WR) && wr_valid;
    assign w_rd_issue = (r_state == RD);
    assign w_advance  = w_wr_beat || w_rd_issue;

    ram_ctrl_addr_gen #(
        .AW (AW),
        .LW (LW)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_accept),
        .i_addr    (cmd_addr),
        .i_len     (cmd_len),
        .i_advance (w_advance),
        .o_addr    (w_cur_addr),
        .o_last    (w_last)
    );

    // ------------------------------------------------------------------
    // Burst FSM. The read or write direction is carried by the state
    // itself, so no separate copy of cmd_we is kept.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= cmd_we ? WR : RD;
                    end
                end
                WR: begin
                    if (wr_valid && w_last) begin
                        r_state <= IDLE;
                    end
                end
                RD: begin
                    if (w_last) begin
                        r_state <= RD_LAST;
                    end
                end
                RD_LAST: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RAM strobes. Write strobes follow wr_valid in the same cycle so a
    // stalled write stream produces a bubble with the bus released. The
    // read tail (RD_LAST) keeps cs/oe up so the RAM keeps driving the
    // final word during the cycle in which it is captured.
    // ------------------------------------------------------------------
    always_comb begin
        ram_cs      = 1'b0;
        ram_we      = 1'b0;
        ram_oe      = 1'b0;
        ram_address = '0;
        case (r_state)
            WR: begin
                ram_cs      = wr_valid;
                ram_we      = wr_valid;
                ram_address = w_cur_addr;
            end
            RD, RD_LAST: begin
                ram_cs      = 1'b1;
                ram_oe      = 1'b1;
                ram_address = w_cur_addr;
            end
            default: begin
                ram_cs = 1'b0;
            end
        endcase
    end

    // The master owns the data bus only during an actual write cycle.
    assign w_drive  = ram_cs && ram_we;
    assign ram_data = w_drive ? wr_data : {DW{1'bz}};

    // ------------------------------------------------------------------
    // Read capture pipeline: tracks which cycles have RAM data on the bus
    // (RD_LAT cycles after issue) and registers it into rd_data.
    // ------------------------------------------------------------------
    generate
        if (RD_LAT == 1) begin : g_pipe_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_issue_pipe <= '0;
                end else begin
                    r_issue_pipe <= w_rd_issue;
                end
            end
        end else begin : g_pipe_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_issue_pipe <= '0;
                end else begin
                    r_issue_pipe <= {r_issue_pipe[RD_LAT-2:0], w_rd_issue};
                end
            end
        end
    endgenerate

    assign w_capture   = r_issue_pipe[RD_LAT-1];
    assign w_pipe_busy = |r_issue_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_capture;
            if (w_capture) begin
                r_rd_data <= ram_data;
            end
        end
    end

    // busy also covers the final rd_valid beat so a new command is never
    // accepted while read data for the previous one is still emerging.
    assign w_busy    = (r_state != IDLE) || w_pipe_busy || r_rd_valid;
    assign busy      = w_busy;
    assign cmd_ready = !w_busy;
    assign wr_ready  = (r_state == WR);
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;

`ifdef RAM_CTRL_STATS_EN
    logic [STAT_W-1:0] r_stat_wr;
    logic [STAT_W-1:0] r_stat_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_wr <= '0;
            r_stat_rd <= '0;
        end else begin
            if (w_wr_beat) begin
                r_stat_wr <= sat_inc(r_stat_wr);
            end
            if (r_rd_valid) begin
                r_stat_rd <= sat_inc(r_stat_rd);
            end
        end
    end

    assign stat_wr_cnt = r_stat_wr;
    assign stat_rd_cnt = r_stat_rd;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_dp_port_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_dp_port_master
// Purpose  : Self-checking bench for ram_dp_port_master with a behavioural
//            RAM port model, a shadow memory and a read-data scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_dp_port_master;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_we = 1'b0;
    logic [7:0] cmd_addr = '0;
    logic [3:0] cmd_len = '0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_data = '0;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       busy;
    logic [7:0] ram_address;
    wire  [7:0] ram_data;
    logic       ram_cs;
    logic       ram_we;
    logic       ram_oe;
`ifdef RAM_CTRL_STATS_EN
    logic [15:0] stat_wr_cnt;
    logic [15:0] stat_rd_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_dp_port_master dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .busy        (busy),
`ifdef RAM_CTRL_STATS_EN
        .stat_wr_cnt (stat_wr_cnt),
        .stat_rd_cnt (stat_rd_cnt),
`endif
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_cs      (ram_cs),
        .ram_we      (ram_we),
        .ram_oe      (ram_oe)
    );

    // ---------------- behavioural RAM port ----------------
    logic [7:0] mem [256];
    logic [7:0] ram_q = '0;

    always @(posedge clk) begin
        if (ram_cs && ram_we) mem[ram_address] <= ram_data;
        else if (ram_cs && ram_oe) ram_q <= mem[ram_address];
    end
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_q : 8'bz;

    // ---------------- checking infrastructure ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [7:0] exp_mem [256];
    logic [7:0] exp_q [$];
    int rv_cnt = 0;
    int rv_first = 0;
    int rv_last = 0;
    int wr_seen = 0;
    int acc_cyc = 0;

    // Read-data scoreboard and bus-rule monitor.
    always @(negedge clk) begin
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                chk("rd_unexpected", 32'd1, 32'd0);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("rd_data", {24'd0, rd_data}, {24'd0, e});
            end
            if (rv_cnt == 0) rv_first = cyc;
            rv_last = cyc;
            rv_cnt++;
        end
        if (ram_cs && ram_we) wr_seen++;
        if (ram_cs) chk("we_oe_excl", {31'd0, ram_we & ram_oe}, 32'd0);
    end

    // ---------------- stimulus tasks ----------------
    task automatic issue(input logic we, input logic [7:0] a, input logic [3:0] l);
        logic ok;
        ok = 1'b0;
        cmd_we = we; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
        for (int g = 0; g < 60 && !ok; g++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                acc_cyc = cyc;
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        chk("cmd_accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic run_write(input logic [7:0] a, input logic [3:0] l, input logic [7:0] base,
                             input logic bubbles, output int beats);
        int beat;
        int t;
        int w0;
        logic v;
        logic [7:0] ea;
        logic [7:0] ed;
        w0 = wr_seen;
        issue(1'b1, a, l);
        beat = 0;
        t = 0;
        while (beat <= int'(l) && t < 80) begin
            v = bubbles ? ((t % 2) == 0) : 1'b1;
            ea = a + 8'(beat);
            ed = base + 8'(beat);
            wr_valid = v;
            wr_data = ed;
            @(negedge clk);
            chk("wr_ready", {31'd0, wr_ready}, 32'd1);
            if (v) begin
                chk("wr_cs", {31'd0, ram_cs}, 32'd1);
                chk("wr_we_oe", {30'd0, ram_we, ram_oe}, 32'd2);
                chk("wr_addr", {24'd0, ram_address}, {24'd0, ea});
                chk("wr_bus", {24'd0, ram_data}, {24'd0, ed});
                exp_mem[ea] = ed;
                beat++;
            end else begin
                chk("bubble_cs_we", {30'd0, ram_cs, ram_we}, 32'd0);
            end
            @(posedge clk); #1;
            t++;
        end
        wr_valid = 1'b0;
        @(negedge clk);
        chk("wr_done_ready", {31'd0, cmd_ready}, 32'd1);
        beats = wr_seen - w0;
    endtask

    task automatic run_read(input logic [7:0] a, input logic [3:0] l, output int pulses, output int lat);
        for (int i = 0; i <= int'(l); i++) exp_q.push_back(exp_mem[8'(a + 8'(i))]);
        rv_cnt = 0;
        issue(1'b0, a, l);
        for (int g = 0; g < 60 && rv_cnt < int'(l) + 1; g++) @(negedge clk);
        chk("rd_timeout", {31'd0, rv_cnt < int'(l) + 1}, 32'd0);
        chk("rd_consecutive", 32'(rv_last - rv_first), 32'(l));
        chk("rd_q_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk("rd_done_ready", {31'd0, cmd_ready}, 32'd1);
        pulses = rv_cnt;
        lat = rv_first - acc_cyc;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [3:0] len;
        logic [7:0] base;
        logic       bubbles;
        int         exp_beats;
        int         exp_lat;
    } vec_t;

    function automatic vec_t mk(logic we, logic [7:0] a, logic [3:0] l, logic [7:0] b,
                                logic bub, int eb, int el);
        vec_t v;
        v.we = we; v.addr = a; v.len = l; v.base = b; v.bubbles = bub;
        v.exp_beats = eb; v.exp_lat = el;
        return v;
    endfunction

    vec_t vecs [10];

    initial begin
        int beats;
        int lat;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00;
            exp_mem[i] = 8'h00;
        end

        vecs[0] = mk(1'b1, 8'h10, 4'd0,  8'hA5, 1'b0, 1,  0);  // single write
        vecs[1] = mk(1'b1, 8'h20, 4'd3,  8'h01, 1'b0, 4,  0);  // 4-beat write
        vecs[2] = mk(1'b0, 8'h20, 4'd3,  8'h00, 1'b0, 4,  3);  // read it back
        vecs[3] = mk(1'b1, 8'h30, 4'd2,  8'h70, 1'b1, 3,  0);  // write with bubbles
        vecs[4] = mk(1'b0, 8'h30, 4'd2,  8'h00, 1'b0, 3,  3);
        vecs[5] = mk(1'b1, 8'hFE, 4'd2,  8'hC0, 1'b0, 3,  0);  // address wrap
        vecs[6] = mk(1'b0, 8'hFE, 4'd2,  8'h00, 1'b0, 3,  3);
        vecs[7] = mk(1'b0, 8'h10, 4'd0,  8'h00, 1'b0, 1,  3);  // single read
        vecs[8] = mk(1'b1, 8'h80, 4'd15, 8'h11, 1'b0, 16, 0);  // max length
        vecs[9] = mk(1'b0, 8'h80, 4'd15, 8'h00, 1'b0, 16, 3);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_flags", {26'd0, wr_ready, rd_valid, busy, ram_cs, ram_we, ram_oe}, 32'd0);
        chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
        chk("rst_address", {24'd0, ram_address}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].we) begin
                run_write(vecs[i].addr, vecs[i].len, vecs[i].base, vecs[i].bubbles, beats);
                chk($sformatf("vec%0d_wr_beats", i), 32'(beats), 32'(vecs[i].exp_beats));
            end else begin
                run_read(vecs[i].addr, vecs[i].len, beats, lat);
                chk($sformatf("vec%0d_rd_pulses", i), 32'(beats), 32'(vecs[i].exp_beats));
                chk($sformatf("vec%0d_rd_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            end
`ifdef RAM_CTRL_STATS_EN
            if (i == 2) begin
                chk("stat_wr_cnt", {16'd0, stat_wr_cnt}, 32'd5);
                chk("stat_rd_cnt", {16'd0, stat_rd_cnt}, 32'd4);
            end
`endif
            @(posedge clk); #1;
        end

        // Command held off while busy: present it during a read burst.
        exp_q.push_back(exp_mem[8'h20]);
        rv_cnt = 0;
        issue(1'b0, 8'h20, 4'd0);
        cmd_we = 1'b0; cmd_addr = 8'h21; cmd_len = 4'd0; cmd_valid = 1'b1;
        @(negedge clk);
        chk("held_off_ready", {31'd0, cmd_ready}, 32'd0);
        chk("held_off_busy", {31'd0, busy}, 32'd1);
        exp_q.push_back(exp_mem[8'h21]);
        for (int g = 0; g < 40 && rv_cnt < 2; g++) @(negedge clk);
        cmd_valid = 1'b0;
        chk("held_off_pulses", 32'(rv_cnt), 32'd2);
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of an 8-beat read, during beat 2.
        rv_cnt = 0;
        issue(1'b0, 8'h40, 4'd7);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_cs", {31'd0, ram_cs}, 32'd0);
        chk("midrst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", {31'd0, cmd_ready}, 32'd1);
`ifdef RAM_CTRL_STATS_EN
        chk("midrst_stats", {stat_wr_cnt, stat_rd_cnt}, 32'd0);
`endif
        repeat (12) @(negedge clk);
        chk("midrst_no_pulses", 32'(rv_cnt), 32'd0);
        @(posedge clk); #1;
        run_read(8'h20, 4'd1, beats, lat);
        chk("postrst_pulses", 32'(beats), 32'd2);
        chk("postrst_latency", 32'(lat), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
